// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: turns stall/flush/redirect requests into per-stage load enables, bubble bits and perf counters.
// Enables are combinational from the current inputs; valids and counters update on the next rising edge.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hz_pc_stall,
    input  logic             i_hz_if_id_stall,
    input  logic             i_hz_id_ex_flush,
    input  logic             i_if_valid,
    input  logic             i_branch_taken,
    input  logic             i_trap_req,
    input  logic             i_ex_busy,
    input  logic             i_mem_wait,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_id_ex_en,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_if_id_valid,
    output logic             o_id_ex_valid,
    output logic             o_ex_mem_valid,
    output logic             o_mem_wb_valid,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count,
    output logic [CNT_W-1:0] o_retired_count
);

    typedef enum logic [2:0] {
        M_NORMAL,
        M_LOADUSE,
        M_BRANCH,
        M_EXBUSY,
        M_TRAP,
        M_MEMWAIT
    } mode_t;

    mode_t            w_mode;
    logic             w_load_use;
    logic             w_flush;
    logic             w_pc_en;
    logic             w_if_id_en;
    logic             w_id_ex_en;
    logic             w_ex_mem_en;
    logic             w_mem_wb_en;
    logic             w_v1_nxt;
    logic             w_v2_nxt;
    logic             w_v3_nxt;
    logic             w_v4_nxt;
    logic             r_v1;
    logic             r_v2;
    logic             r_v3;
    logic             r_v4;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic [CNT_W-1:0] r_retired_count;

    assign w_load_use = i_hz_pc_stall | i_hz_if_id_stall | i_hz_id_ex_flush;

    // Memory wait outranks everything: the redirect sources hold their request until it is honoured.
    always_comb begin
        w_mode = M_NORMAL;
        if (i_mem_wait) begin
            w_mode = M_MEMWAIT;
        end else if (i_trap_req) begin
            w_mode = M_TRAP;
        end else if (i_ex_busy) begin
            w_mode = M_EXBUSY;
        end else if (i_branch_taken) begin
            w_mode = M_BRANCH;
        end else if (w_load_use) begin
            w_mode = M_LOADUSE;
        end
    end

    always_comb begin
        w_pc_en     = 1'b1;
        w_if_id_en  = 1'b1;
        w_id_ex_en  = 1'b1;
        w_ex_mem_en = 1'b1;
        w_mem_wb_en = 1'b1;
        w_v1_nxt    = r_v1;
        w_v2_nxt    = r_v2;
        w_v3_nxt    = r_v3;
        w_v4_nxt    = r_v4;
        case (w_mode)
            M_MEMWAIT: begin
                w_pc_en     = 1'b0;
                w_if_id_en  = 1'b0;
                w_id_ex_en  = 1'b0;
                w_ex_mem_en = 1'b0;
                w_v4_nxt    = 1'b0;
            end
            M_TRAP: begin
                w_v1_nxt = 1'b0;
                w_v2_nxt = 1'b0;
                w_v3_nxt = 1'b0;
                w_v4_nxt = r_v3;
            end
            M_EXBUSY: begin
                w_pc_en    = 1'b0;
                w_if_id_en = 1'b0;
                w_id_ex_en = 1'b0;
                w_v3_nxt   = 1'b0;
                w_v4_nxt   = r_v3;
            end
            M_BRANCH: begin
                w_v1_nxt = 1'b0;
                w_v2_nxt = 1'b0;
                w_v3_nxt = r_v2;
                w_v4_nxt = r_v3;
            end
            M_LOADUSE: begin
                w_pc_en    = 1'b0;
                w_if_id_en = 1'b0;
                w_v2_nxt   = 1'b0;
                w_v3_nxt   = r_v2;
                w_v4_nxt   = r_v3;
            end
            default: begin
                w_v1_nxt = i_if_valid;
                w_v2_nxt = r_v1;
                w_v3_nxt = r_v2;
                w_v4_nxt = r_v3;
            end
        endcase
    end

    assign w_flush = (w_mode == M_TRAP) || (w_mode == M_BRANCH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v1            <= 1'b0;
            r_v2            <= 1'b0;
            r_v3            <= 1'b0;
            r_v4            <= 1'b0;
            r_stall_cycles  <= '0;
            r_flush_count   <= '0;
            r_retired_count <= '0;
        end else begin
            r_v1            <= w_v1_nxt;
            r_v2            <= w_v2_nxt;
            r_v3            <= w_v3_nxt;
            r_v4            <= w_v4_nxt;
            r_stall_cycles  <= sat_inc(r_stall_cycles, !w_pc_en);
            r_flush_count   <= sat_inc(r_flush_count, w_flush);
            r_retired_count <= sat_inc(r_retired_count, r_v4);
        end
    end

    // Enables are held low while reset is asserted, independent of the request inputs.
    assign o_pc_en         = i_rst_n & w_pc_en;
    assign o_if_id_en      = i_rst_n & w_if_id_en;
    assign o_id_ex_en      = i_rst_n & w_id_ex_en;
    assign o_ex_mem_en     = i_rst_n & w_ex_mem_en;
    assign o_mem_wb_en     = i_rst_n & w_mem_wb_en;
    assign o_if_id_valid   = r_v1;
    assign o_id_ex_valid   = r_v2;
    assign o_ex_mem_valid  = r_v3;
    assign o_mem_wb_valid  = r_v4;
    assign o_retire        = r_v4;
    assign o_stall_cycles  = r_stall_cycles;
    assign o_flush_count   = r_flush_count;
    assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl, 4-bit counters so saturation is reachable.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          hz_pc_stall, hz_if_id_stall, hz_id_ex_flush;
    logic          if_valid, branch_taken, trap_req, ex_busy, mem_wait;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          v1, v2, v3, v4, retire;
    logic [CW-1:0] stall_cycles, flush_count, retired_count;

    int n_pass  = 0;
    int n_total = 0;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_hz_pc_stall    (hz_pc_stall),
        .i_hz_if_id_stall (hz_if_id_stall),
        .i_hz_id_ex_flush (hz_id_ex_flush),
        .i_if_valid       (if_valid),
        .i_branch_taken   (branch_taken),
        .i_trap_req       (trap_req),
        .i_ex_busy        (ex_busy),
        .i_mem_wait       (mem_wait),
        .o_pc_en          (pc_en),
        .o_if_id_en       (if_id_en),
        .o_id_ex_en       (id_ex_en),
        .o_ex_mem_en      (ex_mem_en),
        .o_mem_wb_en      (mem_wb_en),
        .o_if_id_valid    (v1),
        .o_id_ex_valid    (v2),
        .o_ex_mem_valid   (v3),
        .o_mem_wb_valid   (v4),
        .o_retire         (retire),
        .o_stall_cycles   (stall_cycles),
        .o_flush_count    (flush_count),
        .o_retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // enables as {pc, if_id, id_ex, ex_mem, mem_wb}
    task automatic chk_en(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(exp));
    endtask

    // valids as {v1, v2, v3, v4}
    task automatic chk_v(input string tag, input logic [3:0] exp);
        chk(tag, 32'({v1, v2, v3, v4}), 32'(exp));
    endtask

    task automatic chk_cnt(input string tag, input int st, input int fl, input int rt);
        chk({tag, "_stall"}, 32'(stall_cycles), 32'(st));
        chk({tag, "_flush"}, 32'(flush_count), 32'(fl));
        chk({tag, "_retired"}, 32'(retired_count), 32'(rt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz_pc_stall = 0; hz_if_id_stall = 0; hz_id_ex_flush = 0;
        if_valid = 0; branch_taken = 0; trap_req = 0; ex_busy = 0; mem_wait = 0;
    endtask

    // Reset, then four NORMAL cycles; pat[3] is fetched first and ends up in v4.
    task automatic reset_fill(input logic [3:0] pat);
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 3; i >= 0; i--) begin
            if_valid = pat[i];
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        if_valid = 1; branch_taken = 1;
        chk_en("rst_en_forced_low", 5'b00000);
        tick();
        tick();
        chk_v("rst_valids", 4'b0000);
        chk_cnt("rst", 0, 0, 0);

        // fill with a continuous fetch stream
        rst_n = 1; branch_taken = 0; if_valid = 1;
        chk_en("normal_en", 5'b11111);
        tick(); chk_v("fill1", 4'b1000);
        tick(); chk_v("fill2", 4'b1100);
        tick(); chk_v("fill3", 4'b1110);
        tick(); chk_v("fill4", 4'b1111);
        chk("retire_follows_v4", 32'(retire), 32'(1));
        chk("retired_before_first", 32'(retired_count), 32'(0));
        tick(); chk("retired_edge5", 32'(retired_count), 32'(1));
        tick(); chk("retired_edge6", 32'(retired_count), 32'(2));
        chk_cnt("fill", 0, 0, 2);

        // single load-use cycle on a full pipe
        reset_fill(4'b1111);
        hz_pc_stall = 1; hz_if_id_stall = 1; hz_id_ex_flush = 1; if_valid = 1;
        chk_en("loaduse_en", 5'b00111);
        tick();
        chk_v("loaduse_bubble", 4'b1011);
        chk_cnt("loaduse", 1, 0, 1);
        idle(); if_valid = 1;
        tick();
        chk_v("loaduse_after", 4'b1101);
        chk("loaduse_one_stall", 32'(stall_cycles), 32'(1));

        // branch beats load-use; v3 takes old v2 while v4 takes old v3
        reset_fill(4'b1011);
        chk_v("branch_pre", 4'b1101);
        branch_taken = 1; hz_pc_stall = 1; hz_if_id_stall = 1; hz_id_ex_flush = 1;
        chk_en("branch_en", 5'b11111);
        tick();
        chk_v("branch_flush", 4'b0010);
        chk_cnt("branch", 0, 1, 1);

        // ex_busy three cycles, branch in the second is ignored
        reset_fill(4'b1111);
        ex_busy = 1;
        chk_en("busy1_en", 5'b00011);
        tick();
        chk_v("busy1", 4'b1101);
        branch_taken = 1;
        chk_en("busy2_en", 5'b00011);
        tick();
        chk_v("busy2", 4'b1100);
        branch_taken = 0;
        chk_en("busy3_en", 5'b00011);
        tick();
        chk_v("busy3", 4'b1100);
        chk_cnt("busy", 3, 0, 2);

        // mem_wait with trap held, then trap is honoured
        reset_fill(4'b1111);
        mem_wait = 1; trap_req = 1;
        chk_en("memwait1_en", 5'b00001);
        tick();
        chk_v("memwait1", 4'b1110);
        chk_en("memwait2_en", 5'b00001);
        tick();
        chk_v("memwait2", 4'b1110);
        chk_cnt("memwait", 2, 0, 1);
        mem_wait = 0;
        chk_en("trap_en", 5'b11111);
        tick();
        chk_v("trap", 4'b0001);
        chk_cnt("trap", 2, 1, 1);
        trap_req = 0;

        // stall counter saturation, then reset mid-stall
        reset_fill(4'b1111);
        hz_pc_stall = 1;
        for (int i = 0; i < 14; i++) tick();
        chk("stall_14", 32'(stall_cycles), 32'(14));
        tick();
        chk("stall_15", 32'(stall_cycles), 32'(15));
        for (int i = 0; i < 5; i++) tick();
        chk("stall_saturated", 32'(stall_cycles), 32'(15));
        chk_v("stall_valids", 4'b1000);
        chk("stall_retired", 32'(retired_count), 32'(3));
        rst_n = 0;
        chk_en("midstall_rst_en", 5'b00000);
        tick();
        chk_v("midstall_rst_valids", 4'b0000);
        chk_cnt("midstall_rst", 0, 0, 0);

        // flush counter saturation under a held branch
        rst_n = 1; hz_pc_stall = 0; branch_taken = 1;
        for (int i = 0; i < 17; i++) tick();
        chk("flush_saturated", 32'(flush_count), 32'(15));
        chk("flush_no_stall", 32'(stall_cycles), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
